// File: rtl/ads4129_delay_cal_if.sv
// Control/observation bundle between the ADS4129 LVDS receiver and its delay
// calibration controller. The slave side is the controller.
interface ads4129_delay_cal_if;
    logic        start;
    logic [11:0] test_pattern;
    logic [11:0] sample_0;
    logic [11:0] sample_1;
    logic [29:0] in_delay_tap_in;
    logic        io_reset;
    logic        in_delay_reset;
    logic [5:0]  in_delay_ce;
    logic [5:0]  in_delay_inc;
    logic        busy;
    logic        done;
    logic [5:0]  lane_fail;
    logic [29:0] final_tap;

    modport master (
        output start, test_pattern, sample_0, sample_1, in_delay_tap_in,
        input  io_reset, in_delay_reset, in_delay_ce, in_delay_inc,
               busy, done, lane_fail, final_tap
    );

    modport slave (
        input  start, test_pattern, sample_0, sample_1, in_delay_tap_in,
        output io_reset, in_delay_reset, in_delay_ce, in_delay_inc,
               busy, done, lane_fail, final_tap
    );
endinterface

// File: rtl/ads4129_delay_cal.sv
// Per-lane IDELAY sweep: scores every tap against a fixed ADC test pattern and
// parks each of the 6 lanes at the centre of its widest passing window.
module ads4129_delay_cal #(
    parameter int P_TAPS          = 32,
    parameter int P_SETTLE        = 16,
    parameter int P_COMPARE       = 64,
    parameter int P_MIN_EYE       = 4,
    parameter int P_IO_RST_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ads4129_delay_cal_if.slave bus
);
    localparam int NL = 6;
    localparam int TW = $clog2(P_TAPS);
    localparam int LW = $clog2(P_TAPS + 1);
    localparam int CW = 16;

    typedef enum logic [3:0] {
        S_IDLE, S_IO_RST, S_DLY_RST, S_SETTLE, S_COMPARE, S_SCORE, S_STEP,
        S_SEEK, S_SEEK_GAP, S_CHECK, S_NEXT_LANE, S_DONE
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [2:0]      lane_reg;
    logic [TW-1:0]   tap_reg;
    logic [TW-1:0]   target_reg;
    logic [TW-1:0]   cur_start_reg;
    logic [LW-1:0]   cur_len_reg;
    logic [TW-1:0]   best_start_reg;
    logic [LW-1:0]   best_len_reg;
    logic            sticky_reg;
    logic            err_reg;
    logic            io_reset_reg;
    logic            in_delay_reset_reg;
    logic [NL-1:0]   in_delay_ce_reg;
    logic [NL-1:0]   in_delay_inc_reg;
    logic            busy_reg;
    logic            done_reg;
    logic [NL-1:0]   lane_fail_reg;
    logic [NL*TW-1:0] final_tap_reg;

    logic [11:0]     diff;
    logic [NL-1:0]   lane_err;
    logic [TW-1:0]   tap_rb [NL];

    assign diff = (bus.sample_0 ^ bus.test_pattern) | (bus.sample_1 ^ bus.test_pattern);

    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lane
            assign lane_err[gi] = |diff[2*gi +: 2];
            assign tap_rb[gi]   = bus.in_delay_tap_in[TW*gi +: TW];
        end
    endgenerate

    // The error seen on the last compare cycle lands in err_reg during SCORE.
    logic            pass;
    logic [LW-1:0]   run_len;
    logic [TW-1:0]   run_start;
    logic            eye_ok;
    logic [TW-1:0]   half_len;
    logic [TW-1:0]   target_calc;

    assign pass        = !(sticky_reg | err_reg);
    assign run_len     = pass ? cur_len_reg + LW'(1) : '0;
    assign run_start   = (cur_len_reg == '0) ? tap_reg : cur_start_reg;
    assign eye_ok      = best_len_reg >= LW'(P_MIN_EYE);
    assign half_len    = TW'((best_len_reg - LW'(1)) >> 1);
    assign target_calc = eye_ok ? best_start_reg + half_len : TW'(P_TAPS/2 - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= S_IDLE;
            cnt_reg            <= '0;
            lane_reg           <= '0;
            tap_reg            <= '0;
            target_reg         <= '0;
            cur_start_reg      <= '0;
            cur_len_reg        <= '0;
            best_start_reg     <= '0;
            best_len_reg       <= '0;
            sticky_reg         <= 1'b0;
            err_reg            <= 1'b0;
            io_reset_reg       <= 1'b0;
            in_delay_reset_reg <= 1'b0;
            in_delay_ce_reg    <= '0;
            in_delay_inc_reg   <= '0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
            lane_fail_reg      <= '0;
            final_tap_reg      <= '0;
        end else begin
            err_reg            <= lane_err[lane_reg];
            in_delay_ce_reg    <= '0;
            in_delay_inc_reg   <= '0;
            in_delay_reset_reg <= 1'b0;
            done_reg           <= 1'b0;
            case (state_reg)
                S_IDLE: if (bus.start) begin
                    busy_reg      <= 1'b1;
                    io_reset_reg  <= 1'b1;
                    lane_fail_reg <= '0;
                    final_tap_reg <= '0;
                    cnt_reg       <= CW'(P_IO_RST_CYCLES - 1);
                    state_reg     <= S_IO_RST;
                end
                S_IO_RST: if (cnt_reg == '0) begin
                    io_reset_reg       <= 1'b0;
                    in_delay_reset_reg <= 1'b1;
                    state_reg          <= S_DLY_RST;
                end else cnt_reg <= cnt_reg - CW'(1);
                S_DLY_RST: begin
                    lane_reg       <= '0;
                    tap_reg        <= '0;
                    cur_start_reg  <= '0;
                    cur_len_reg    <= '0;
                    best_start_reg <= '0;
                    best_len_reg   <= '0;
                    cnt_reg        <= CW'(P_SETTLE - 1);
                    state_reg      <= S_SETTLE;
                end
                S_SETTLE: if (cnt_reg == '0) begin
                    sticky_reg <= 1'b0;
                    cnt_reg    <= CW'(P_COMPARE - 1);
                    state_reg  <= S_COMPARE;
                end else cnt_reg <= cnt_reg - CW'(1);
                S_COMPARE: begin
                    // err_reg on the first compare cycle still reflects settle time.
                    if (cnt_reg != CW'(P_COMPARE - 1)) sticky_reg <= sticky_reg | err_reg;
                    if (cnt_reg == '0) state_reg <= S_SCORE;
                    else cnt_reg <= cnt_reg - CW'(1);
                end
                S_SCORE: begin
                    cur_len_reg <= run_len;
                    if (pass && cur_len_reg == '0) cur_start_reg <= tap_reg;
                    if (run_len > best_len_reg) begin
                        best_len_reg   <= run_len;
                        best_start_reg <= run_start;
                    end
                    state_reg <= S_STEP;
                end
                S_STEP: if (tap_reg < TW'(P_TAPS - 1)) begin
                    in_delay_ce_reg[lane_reg]  <= 1'b1;
                    in_delay_inc_reg[lane_reg] <= 1'b1;
                    tap_reg   <= tap_reg + TW'(1);
                    cnt_reg   <= CW'(P_SETTLE - 1);
                    state_reg <= S_SETTLE;
                end else begin
                    target_reg <= target_calc;
                    if (!eye_ok) lane_fail_reg[lane_reg] <= 1'b1;
                    state_reg <= S_SEEK;
                end
                S_SEEK: if (tap_reg > target_reg) begin
                    in_delay_ce_reg[lane_reg] <= 1'b1;
                    tap_reg   <= tap_reg - TW'(1);
                    cnt_reg   <= CW'(1);
                    state_reg <= S_SEEK_GAP;
                end else begin
                    cnt_reg   <= CW'(P_SETTLE - 1);
                    state_reg <= S_CHECK;
                end
                S_SEEK_GAP: if (cnt_reg == '0) state_reg <= S_SEEK;
                            else cnt_reg <= cnt_reg - CW'(1);
                S_CHECK: if (cnt_reg == '0) begin
                    if (tap_rb[lane_reg] != target_reg) lane_fail_reg[lane_reg] <= 1'b1;
                    final_tap_reg[lane_reg*TW +: TW] <= target_reg;
                    state_reg <= S_NEXT_LANE;
                end else cnt_reg <= cnt_reg - CW'(1);
                S_NEXT_LANE: if (lane_reg < 3'(NL - 1)) begin
                    lane_reg       <= lane_reg + 3'd1;
                    tap_reg        <= '0;
                    cur_start_reg  <= '0;
                    cur_len_reg    <= '0;
                    best_start_reg <= '0;
                    best_len_reg   <= '0;
                    cnt_reg        <= CW'(P_SETTLE - 1);
                    state_reg      <= S_SETTLE;
                end else begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= S_DONE;
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.io_reset       = io_reset_reg;
    assign bus.in_delay_reset = in_delay_reset_reg;
    assign bus.in_delay_ce    = in_delay_ce_reg;
    assign bus.in_delay_inc   = in_delay_inc_reg;
    assign bus.busy           = busy_reg;
    assign bus.done           = done_reg;
    assign bus.lane_fail      = lane_fail_reg;
    assign bus.final_tap      = final_tap_reg;
endmodule

// File: tb/tb_ads4129_delay_cal.sv
// Bench for ads4129_delay_cal: IDELAY/receiver model, reference window search,
// and a done-triggered scoreboard.
module tb_ads4129_delay_cal;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #4 clk = ~clk;

    ads4129_delay_cal_if bus();

    ads4129_delay_cal dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [29:0] tap;
        logic [5:0]  fail;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          done_seen = 0;
    int          illegal = 0;
    int          io_len = 0;
    logic [31:0] pass_mask [6];
    logic        stuck3 = 1'b0;
    logic [4:0]  mtap [6];
    int          up_cnt [6];
    int          dn_cnt [6];
    logic [23:0] noise = 24'h111111;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {12'd0, bus.io_reset, bus.in_delay_reset, bus.in_delay_ce, bus.in_delay_inc,
                bus.busy, bus.done, bus.lane_fail, bus.final_tap};
    endfunction

    // Reference: widest run of passing taps, lowest start on ties.
    function automatic void ref_lane(input logic [31:0] m, input logic stuck,
                                     output logic [4:0] tgt, output logic fl);
        int i = 0;
        int s;
        int bl = 0;
        int bs = 0;
        logic [4:0] rb;
        while (i < 32) begin
            if (m[i]) begin
                s = i;
                while (i < 32 && m[i]) i++;
                if (i - s > bl) begin bl = i - s; bs = s; end
            end else i++;
        end
        tgt = (bl >= 4) ? 5'(bs + (bl - 1) / 2) : 5'd15;
        rb  = stuck ? 5'd0 : tgt;
        fl  = (bl < 4) || (rb != tgt);
    endfunction

    function automatic exp_t make_exp();
        exp_t e;
        logic [4:0] t;
        logic f;
        e = '0;
        for (int l = 0; l < 6; l++) begin
            ref_lane(pass_mask[l], (l == 3) && stuck3, t, f);
            e.tap[5*l +: 5] = t;
            e.fail[l] = f;
        end
        return e;
    endfunction

    function automatic logic [31:0] win(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int k = lo; k <= hi; k++) m[k] = 1'b1;
        return m;
    endfunction

    // Receiver + IDELAY model: failing taps corrupt at least one bit of the lane pair.
    always @(negedge clk)
        for (int l = 0; l < 6; l++) noise[4*l +: 4] <= 4'($urandom_range(1, 15));

    always @(posedge clk) begin
        for (int l = 0; l < 6; l++) begin
            if (bus.in_delay_reset) begin
                mtap[l] <= '0; up_cnt[l] <= 0; dn_cnt[l] <= 0;
            end else if (bus.in_delay_ce[l]) begin
                if (bus.in_delay_inc[l]) begin mtap[l] <= mtap[l] + 5'd1; up_cnt[l] <= up_cnt[l] + 1; end
                else begin mtap[l] <= mtap[l] - 5'd1; dn_cnt[l] <= dn_cnt[l] + 1; end
            end
            bus.sample_0[2*l +: 2] <= pass_mask[l][mtap[l]] ? bus.test_pattern[2*l +: 2]
                                      : bus.test_pattern[2*l +: 2] ^ noise[4*l +: 2];
            bus.sample_1[2*l +: 2] <= pass_mask[l][mtap[l]] ? bus.test_pattern[2*l +: 2]
                                      : bus.test_pattern[2*l +: 2] ^ noise[4*l+2 +: 2];
        end
    end

    always_comb begin
        bus.in_delay_tap_in = '0;
        for (int l = 0; l < 6; l++)
            bus.in_delay_tap_in[5*l +: 5] = (l == 3 && stuck3) ? 5'd0 : mtap[l];
    end

    initial begin : monitor
        exp_t e;
        logic [47:0] ua, ue, da, de;
        logic io_prev;
        io_prev = 1'b0;
        forever begin
            @(negedge clk);
            if ($countones(bus.in_delay_ce) > 1 || (bus.in_delay_inc & ~bus.in_delay_ce) != 0)
                illegal++;
            if (bus.io_reset) io_len = io_prev ? io_len + 1 : 1;
            io_prev = bus.io_reset;
            if (bus.done) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    for (int l = 0; l < 6; l++) begin
                        ua[8*l +: 8] = 8'(up_cnt[l]);
                        ue[8*l +: 8] = 8'd31;
                        da[8*l +: 8] = 8'(dn_cnt[l]);
                        de[8*l +: 8] = 8'(31 - int'(e.tap[5*l +: 5]));
                    end
                    $display("done #%0d: final_tap=%h lane_fail=%b (expected %h %b)",
                             done_seen, bus.final_tap, bus.lane_fail, e.tap, e.fail);
                    chk("final_tap", 64'(bus.final_tap), 64'(e.tap));
                    chk("lane_fail", 64'(bus.lane_fail), 64'(e.fail));
                    chk("busy_low_at_done", 64'(bus.busy), 64'd0);
                    chk("ce_up_counts", 64'(ua), 64'(ue));
                    chk("ce_down_counts", 64'(da), 64'(de));
                    chk("io_reset_len", 64'(io_len), 64'd8);
                end
            end
        end
    end

    task automatic do_start(input bit push);
        bus.test_pattern = 12'($urandom);
        if (push) exp_q.push_back(make_exp());
        @(posedge clk); #1;
        chk("busy_before_start", 64'(bus.busy), 64'd0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_io_reset_after_start", 64'({bus.busy, bus.io_reset}), 64'b11);
    endtask

    task automatic wait_done();
        int n = 0;
        int base = done_seen;
        while (done_seen == base && n < 25000) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk("done_within_budget", 64'(done_seen - base), 64'd1);
    endtask

    task automatic set_clean();
        for (int l = 0; l < 6; l++) pass_mask[l] = win(10, 20);
        stuck3 = 1'b0;
    endtask

    initial begin : stim
        int n;
        bus.start = 1'b0;
        bus.test_pattern = '0;
        set_clean();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("reset_outputs", outs(), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // clean sweep, with a start pulse while busy that must be ignored
        do_start(1'b1);
        repeat (3000) @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done();

        // mixed windows: tie, open end, full range, short eye
        pass_mask[0] = 32'hFFFF_FFFF;
        pass_mask[1] = win(2, 5) | win(9, 12);
        pass_mask[2] = win(3, 6) | win(20, 27);
        pass_mask[3] = win(10, 20);
        pass_mask[4] = win(7, 9);
        pass_mask[5] = win(26, 31);
        do_start(1'b1);
        wait_done();

        // random windows, lane 3 readback stuck at 0
        for (int l = 0; l < 6; l++) begin
            pass_mask[l] = '0;
            repeat ($urandom_range(1, 3)) begin
                int s;
                int len;
                s = $urandom_range(0, 31);
                len = $urandom_range(1, 14);
                pass_mask[l] = pass_mask[l] | win(s, (s + len - 1 > 31) ? 31 : s + len - 1);
            end
        end
        pass_mask[3] = win(8, 18);
        stuck3 = 1'b1;
        do_start(1'b1);
        wait_done();

        // abort mid-compare on lane 2
        set_clean();
        do_start(1'b0);
        n = 0;
        while (up_cnt[2] < 5 && n < 20000) begin @(negedge clk); n++; end
        chk("lane2_sweep_reached", 64'(up_cnt[2] >= 5), 64'd1);
        repeat (40) @(negedge clk);
        chk("busy_before_abort", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("abort_outputs_zero", outs(), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // rerun must reproduce the clean result
        do_start(1'b1);
        wait_done();

        chk("done_count", 64'(done_seen), 64'd4);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("ce_inc_legal", 64'(illegal), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
